// File: rtl/timebase_pkg.sv
// Shared timebase constants for the millisecond tick generator and its decade stages.
package timebase_pkg;

  localparam int CLK_HZ_DEFAULT = 50_000_000;
  localparam int DECADE         = 10;
  localparam int MS_PER_TICK [4] = '{1, 10, 100, 1000};

  // Clocks per millisecond; callers guarantee clk_hz is a multiple of 1000.
  function automatic int calc_div(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/ms_tick_gen_if.sv
// Control inputs and strobe outputs of the millisecond timebase.
interface ms_tick_gen_if;

  logic enable;
  logic clear;
  logic ms1;
  logic ms10;
  logic ms100;
  logic sec1;

  modport master (
    output enable,
    output clear,
    input  ms1,
    input  ms10,
    input  ms100,
    input  sec1
  );

  modport slave (
    input  enable,
    input  clear,
    output ms1,
    output ms10,
    output ms100,
    output sec1
  );

endinterface

// File: rtl/decade_stage.sv
// One mod-10 stage of the timebase cascade; advances only on carry_in.
module decade_stage
  import timebase_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic carry_in,
  output logic carry_out
);

  localparam logic [3:0] LAST = 4'(DECADE - 1);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (carry_in) begin
      count <= (count == LAST) ? 4'd0 : count + 4'd1;
    end
  end

  assign carry_out = carry_in && (count == LAST);

endmodule

// File: rtl/ms_tick_gen.sv
// Free-running timebase: prescaler plus three cascaded decade stages, registered strobes.
module ms_tick_gen
  import timebase_pkg::*;
#(
  parameter int CLK_HZ = CLK_HZ_DEFAULT,
  parameter int DIV    = calc_div(CLK_HZ)
) (
  input  logic          clk,
  input  logic          rst,
  ms_tick_gen_if.slave  bus
);

  localparam int             PRE_W   = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             wrap;
  logic             c10;
  logic             c100;
  logic             c1000;

  // A disabled edge never wraps, so the phase freezes at DIV-1 / 9 if caught there.
  assign wrap = bus.enable && (pre == PRE_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (bus.clear) begin
      pre <= '0;
    end else if (bus.enable) begin
      pre <= wrap ? '0 : pre + 1'b1;
    end
  end

  decade_stage u_d10 (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clear),
    .carry_in  (wrap),
    .carry_out (c10)
  );

  decade_stage u_d100 (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clear),
    .carry_in  (c10),
    .carry_out (c100)
  );

  decade_stage u_d1000 (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.clear),
    .carry_in  (c100),
    .carry_out (c1000)
  );

  // Strobes come straight from the carry chain, so higher ones always coincide with lower ones.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      bus.ms1   <= 1'b0;
      bus.ms10  <= 1'b0;
      bus.ms100 <= 1'b0;
      bus.sec1  <= 1'b0;
    end else begin
      bus.ms1   <= wrap;
      bus.ms10  <= c10;
      bus.ms100 <= c100;
      bus.sec1  <= c1000;
    end
  end

endmodule

// File: tb/tb_ms_tick_gen.sv
// Directed bench for ms_tick_gen at CLK_HZ=10_000 (DIV=10).
module tb_ms_tick_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ms_tick_gen_if bus ();

  ms_tick_gen #(.CLK_HZ(10_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.clear = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      tests++;
      if ({bus.ms1, bus.ms10, bus.ms100, bus.sec1} !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL reset: strobes=%b required 0000", {bus.ms1, bus.ms10, bus.ms100, bus.sec1});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    logic [3:0] exp;
    reset_dut();
    bus.enable = 1'b1;
    for (int n = 1; n <= 10_000; n++) begin
      tick();
      exp = {n % 10 == 0, n % 100 == 0, n % 1000 == 0, n == 10_000};
      tests++;
      if ({bus.ms1, bus.ms10, bus.ms100, bus.sec1} !== exp) begin
        fails++;
        $display("[TB] FAIL free_run edge %0d: strobes=%b required %b", n,
                 {bus.ms1, bus.ms10, bus.ms100, bus.sec1}, exp);
      end
    end
  endtask

  task automatic test_enable_gap();
    logic exp;
    reset_dut();
    bus.enable = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      bus.enable = !(n >= 6 && n <= 42);
      tick();
      exp = (n == 47) || (n == 57);
      tests++;
      if (bus.ms1 !== exp || {bus.ms10, bus.ms100, bus.sec1} !== 3'b000) begin
        fails++;
        $display("[TB] FAIL enable_gap edge %0d: ms1=%b others=%b required ms1=%b others=000", n,
                 bus.ms1, {bus.ms10, bus.ms100, bus.sec1}, exp);
      end
    end
    // Disable exactly on the wrap edge: phase holds at DIV-1, wrap occurs on re-enable.
    reset_dut();
    for (int n = 1; n <= 14; n++) begin
      bus.enable = !(n >= 10 && n <= 13);
      tick();
      exp = (n == 14);
      tests++;
      if (bus.ms1 !== exp) begin
        fails++;
        $display("[TB] FAIL disable_at_wrap edge %0d: ms1=%b required %b", n, bus.ms1, exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [3:0] exp;
    int e;
    reset_dut();
    bus.enable = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      bus.clear = (n == 995);
      tick();
      if (n < 995) begin
        e = n;
        exp = {e % 10 == 0, e % 100 == 0, e % 1000 == 0, 1'b0};
      end else if (n == 995) begin
        exp = 4'b0000;
      end else begin
        e = n - 995;
        exp = {e % 10 == 0, e % 100 == 0, e % 1000 == 0, 1'b0};
      end
      tests++;
      if ({bus.ms1, bus.ms10, bus.ms100, bus.sec1} !== exp) begin
        fails++;
        $display("[TB] FAIL clear edge %0d: strobes=%b required %b", n,
                 {bus.ms1, bus.ms10, bus.ms100, bus.sec1}, exp);
      end
    end
    bus.clear = 1'b0;
    // Clear on the wrap edge suppresses that ms1.
    reset_dut();
    bus.enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      bus.clear = (n == 10);
      tick();
      tests++;
      if (bus.ms1 !== (n == 20)) begin
        fails++;
        $display("[TB] FAIL clear_at_wrap edge %0d: ms1=%b required %b", n, bus.ms1, n == 20);
      end
    end
    bus.clear = 1'b0;
  endtask

  task automatic test_rst_mid();
    logic [3:0] exp;
    reset_dut();
    bus.enable = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      rst = (n == 1000);
      tick();
      exp = (n == 1000) ? 4'b0000 : {n % 10 == 0, n % 100 == 0, n % 1000 == 0, 1'b0};
      tests++;
      if ({bus.ms1, bus.ms10, bus.ms100, bus.sec1} !== exp) begin
        fails++;
        $display("[TB] FAIL rst_mid edge %0d: strobes=%b required %b", n,
                 {bus.ms1, bus.ms10, bus.ms100, bus.sec1}, exp);
      end
    end
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      tests++;
      if (bus.ms1 !== (n % 10 == 0)) begin
        fails++;
        $display("[TB] FAIL rst_recover edge %0d: ms1=%b required %b", n, bus.ms1, n % 10 == 0);
      end
    end
  endtask

  task automatic test_rst_clear_width();
    logic [3:0] cur;
    logic [3:0] prev;
    int ms1_count;
    rst = 1'b1;
    bus.clear = 1'b1;
    bus.enable = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      tick();
      tests++;
      if ({bus.ms1, bus.ms10, bus.ms100, bus.sec1} !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL rst_clear edge %0d: strobes=%b required 0000", n,
                 {bus.ms1, bus.ms10, bus.ms100, bus.sec1});
      end
    end
    rst = 1'b0;
    bus.clear = 1'b0;
    prev = 4'b0000;
    ms1_count = 0;
    for (int n = 1; n <= 20_000; n++) begin
      tick();
      cur = {bus.ms1, bus.ms10, bus.ms100, bus.sec1};
      if (cur[3]) ms1_count++;
      tests++;
      if ((cur & prev) !== 4'b0000) begin
        fails++;
        $display("[TB] FAIL width edge %0d: strobes=%b after %b required no overlap", n, cur, prev);
      end
      tests++;
      if ((cur[0] && !cur[1]) || (cur[1] && !cur[2]) || (cur[2] && !cur[3])) begin
        fails++;
        $display("[TB] FAIL coincidence edge %0d: strobes=%b required nested", n, cur);
      end
      prev = cur;
    end
    tests++;
    if (ms1_count != 2000) begin
      fails++;
      $display("[TB] FAIL ms1_count: got %0d required 2000", ms1_count);
    end
  endtask

  task automatic test_timeout();
    int last;
    int tcount;
    int timeouts;
    reset_dut();
    bus.enable = 1'b1;
    last = 0;
    tcount = 0;
    timeouts = 0;
    for (int n = 1; n <= 11_000; n++) begin
      tick();
      if (bus.ms100 === 1'b1) begin
        tests++;
        if (n - last != 1000) begin
          fails++;
          $display("[TB] FAIL ms100_spacing edge %0d: spacing=%0d required 1000", n, n - last);
        end
        last = n;
        if (tcount == 10) begin
          tcount = 0;
          timeouts++;
          tests++;
          if (n != 11_000) begin
            fails++;
            $display("[TB] FAIL timeout edge: got %0d required 11000", n);
          end
        end else begin
          tcount++;
        end
      end
    end
    tests++;
    if (timeouts != 1) begin
      fails++;
      $display("[TB] FAIL timeout_count: got %0d required 1", timeouts);
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_free_run();
    test_enable_gap();
    test_clear();
    test_rst_mid();
    test_rst_clear_width();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ms_tick_gen.md
# ms_tick_gen

Free-running timebase that divides the system clock into one-cycle strobes at 1 ms, 10 ms, 100 ms and 1 s. It drives the `ms100` input of the speed/timeout counters and any other block that counts decimal time. Counting is cascaded: a prescaler feeds three mod-10 decade stages, and all strobes are registered.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz. Must be a multiple of 1000 with CLK_HZ/1000 ≥ 2.
- `DIV`, default CLK_HZ/1000: prescaler modulus (clocks per 1 ms). Derived; do not override.

- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `enable` input 1: 1 = advance the timebase; 0 = freeze all counters.
- `clear` input 1: synchronous restart of the timebase phase (all counters to 0).
- `ms1` output 1: one-cycle strobe every 1 ms.
- `ms10` output 1: one-cycle strobe every 10 ms.
- `ms100` output 1: one-cycle strobe every 100 ms.
- `sec1` output 1: one-cycle strobe every 1 s.

Single clock. Reset is synchronous and active-high.

## Operation
- Prescaler `pre` has width $clog2(DIV) and counts 0..DIV-1.
- Decade stages `d10`, `d100` and `d1000` are 4 bits each and count 0..9.
- Priority per edge: `rst` > `clear` > `enable`.
- On `rst` or `clear`:
  - all counters go to 0;
  - all strobes go to 0 on that edge.
- `enable`=1:
  - `pre` increments. At `pre`==DIV-1 it wraps to 0 and sets `ms1`<=1 for the next cycle.
  - Carry into `d10` occurs on the `pre` wrap. At `d10`==9 with carry, `d10` wraps and `ms10`<=1.
  - `d100` and `d1000` cascade the same way, producing `ms100` and `sec1`.
  - A stage advances only on its carry-in; there is no free-running increment.
- `enable`=0:
  - all counter values hold;
  - all strobes are 0 next cycle.
  - On re-enable, counting resumes from the held phase; phase is not lost.
- Coincidence:
  - `sec1` ⇒ `ms100` ⇒ `ms10` ⇒ `ms1`, all high in the same cycle.
  - Higher strobes are never high without all lower ones.
- Strobes are never high for two consecutive cycles (DIV ≥ 2).

## Timing
- All outputs are registered. Reset value is 0 for every output and counter.
- After `rst` deasserts with `enable` held at 1:
  - first `ms1` is high in the cycle after the DIV-th enabled edge;
  - `ms10` after 10·DIV edges;
  - `ms100` after 100·DIV edges;
  - `sec1` after 1000·DIV edges.
- Period is exactly DIV, 10·DIV, 100·DIV and 1000·DIV enabled cycles respectively. Disabled cycles do not count.
- Latency is one cycle from the wrap-qualifying edge to the strobe being visible. `clear` and `rst` suppress a strobe that would otherwise appear on the same edge.
- `clear` or `rst` asserted mid-count: the next `ms1` comes exactly DIV enabled edges after deassertion.
- `enable` deasserted in the same edge as a wrap: the wrap does not happen and counters hold at DIV-1 / 9.
- Consumers sample strobes on the same `clk`. No synchronizer is needed.

## Structure
- Shared package `timebase_pkg`:
  - `CLK_HZ_DEFAULT`;
  - `MS_PER_TICK` constants (1, 10, 100, 1000);
  - `DECADE` = 10;
  - a function computing DIV.
- Sub-module `decade_stage`:
  - ports `clk`, `rst`, `clr`, `carry_in`, `carry_out`;
  - holds a 4-bit mod-10 counter;
  - `carry_out` = `carry_in` && count==9;
  - instantiated three times, chained.
- The top level contains the prescaler, the enable/clear qualification and the four strobe registers.

## Test plan
All scenarios use `CLK_HZ`=10_000, so DIV=10.

1. Reset, then `enable`=1 for 10_000 cycles:
   - `ms1` at cycles 10, 20, …;
   - `ms10` at cycles 100, 200, …;
   - `ms100` at cycles 1000, 2000, …;
   - `sec1` once, at cycle 10_000, coincident with all other strobes.
2. `enable`=0 for 37 cycles starting at cycle 5, then re-enabled: first `ms1` at cycle 47, and no strobes during the gap.
3. `clear` pulsed at cycle 995: no `ms100` at cycle 1000; next `ms1` at cycle 1005 and next `ms100` at cycle 1995.
4. `rst` asserted at cycle 1000, the cycle `ms100` would rise: all outputs 0 that cycle; first `ms1` 10 cycles after `rst` drops.
5. `rst` and `clear` both high with `enable`=1: outputs and counters stay 0 for the duration. Check every strobe's width is exactly 1 cycle over a 20_000-cycle run.
6. Connect `ms100` to the speed/timeout counter:
   - with speed 0, `timeout` pulses every 11 `ms100` strobes (count runs 0..10 inclusive);
   - strobe spacing stays exactly 1000 cycles.
